// File: rtl/alt_mem_ddrx_ecc_scrub_ctrl_if.sv
// Scrub command handshake between the ECC scrub controller (master) and the
// command arbiter (slave): request/address out, acknowledge/done back.
interface alt_mem_ddrx_ecc_scrub_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              scrub_req;
   logic [ADDR_W-1:0] scrub_addr;
   logic              scrub_ack;
   logic              scrub_done;

   modport master (output scrub_req, output scrub_addr, input scrub_ack, input scrub_done);
   modport slave  (input scrub_req, input scrub_addr, output scrub_ack, output scrub_done);
endinterface

// File: rtl/alt_mem_ddrx_ecc_scrub_ctrl.sv
// ECC error qualification, saturating SBE/DBE counters, sticky interrupt and
// SBE scrub queue/sequencer. Optional address logging: ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN.
module alt_mem_ddrx_ecc_scrub_ctrl #(
   parameter int CFG_LOCAL_ADDR_WIDTH = 32,
   parameter int CFG_ERR_CNT_WIDTH    = 8,
   parameter int CFG_SCRUB_FIFO_DEPTH = 4
) (
   input  logic                            ctl_clk,
   input  logic                            ctl_reset_n,
   input  logic                            cfg_enable_ecc,
   input  logic                            cfg_enable_auto_corr,
   input  logic                            cfg_err_intr_en,
   input  logic                            cfg_clr_intr,
   input  logic                            rdata_valid,
   input  logic [CFG_LOCAL_ADDR_WIDTH-1:0] rdata_addr,
   input  logic                            err_corrected,
   input  logic                            err_fatal,
   alt_mem_ddrx_ecc_scrub_ctrl_if.master   scrub_if,
   output logic [CFG_ERR_CNT_WIDTH-1:0]    sbe_count,
   output logic [CFG_ERR_CNT_WIDTH-1:0]    dbe_count,
   output logic                            err_intr,
   output logic                            scrub_overflow,
   output logic                            scrub_busy
`ifdef ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN
   ,
   output logic [CFG_LOCAL_ADDR_WIDTH-1:0] first_err_addr,
   output logic [CFG_LOCAL_ADDR_WIDTH-1:0] last_err_addr,
   output logic                            first_err_is_dbe
`endif
);

   localparam int PTR_W = $clog2(CFG_SCRUB_FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   function automatic logic [CFG_ERR_CNT_WIDTH-1:0] sat_inc(input logic [CFG_ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t                          state_q;
   logic                            req_q;
   logic [CFG_LOCAL_ADDR_WIDTH-1:0] addr_q;
   logic [CFG_ERR_CNT_WIDTH-1:0]    sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
   logic                            intr_q, intr_d, ovf_q, ovf_d;
   logic [PTR_W:0]                  wr_ptr_q, rd_ptr_q;
   logic [CFG_LOCAL_ADDR_WIDTH-1:0] mem_q [CFG_SCRUB_FIFO_DEPTH];

   logic sbe_ev, dbe_ev, any_ev;
   logic q_empty, q_full, push_req, push, pop, drop;

   assign sbe_ev = cfg_enable_ecc & rdata_valid & err_corrected & ~err_fatal;
   assign dbe_ev = cfg_enable_ecc & rdata_valid & err_fatal;
   assign any_ev = sbe_ev | dbe_ev;

   assign q_empty  = (wr_ptr_q == rd_ptr_q);
   assign q_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop      = (state_q == S_WAIT) & scrub_if.scrub_done;
   assign push_req = sbe_ev & cfg_enable_auto_corr;
   // A full queue still accepts when the head leaves in the same cycle.
   assign push     = push_req & (~q_full | pop);
   assign drop     = push_req & q_full & ~pop;

   // Clear first, then let a same-cycle event land on top of the cleared value.
   always_comb begin
      sbe_cnt_d = cfg_clr_intr ? '0 : sbe_cnt_q;
      dbe_cnt_d = cfg_clr_intr ? '0 : dbe_cnt_q;
      if (sbe_ev) sbe_cnt_d = sat_inc(sbe_cnt_d);
      if (dbe_ev) dbe_cnt_d = sat_inc(dbe_cnt_d);
      intr_d = (any_ev & cfg_err_intr_en) ? 1'b1 : (cfg_clr_intr ? 1'b0 : intr_q);
      ovf_d  = drop ? 1'b1 : (cfg_clr_intr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
      if (!ctl_reset_n) begin
         sbe_cnt_q <= '0;
         dbe_cnt_q <= '0;
         intr_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         sbe_cnt_q <= sbe_cnt_d;
         dbe_cnt_q <= dbe_cnt_d;
         intr_q    <= intr_d;
         ovf_q     <= ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge ctl_clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= rdata_addr;
   end

   // Scrub sequencer; the head entry stays queued until its write-back is done.
   always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
      if (!ctl_reset_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (!q_empty && cfg_enable_auto_corr) begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
               addr_q  <= mem_q[rd_ptr_q[PTR_W-1:0]];
            end
            S_REQ: if (scrub_if.scrub_ack) begin
               state_q <= S_WAIT;
               req_q   <= 1'b0;
            end
            S_WAIT: if (scrub_if.scrub_done) state_q <= S_IDLE;
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign scrub_if.scrub_req  = req_q;
   assign scrub_if.scrub_addr = addr_q;
   assign sbe_count           = sbe_cnt_q;
   assign dbe_count           = dbe_cnt_q;
   assign err_intr            = intr_q;
   assign scrub_overflow      = ovf_q;
   assign scrub_busy          = (state_q != S_IDLE) | ~q_empty;

`ifdef ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN
   logic                            first_seen_q, first_dbe_q;
   logic [CFG_LOCAL_ADDR_WIDTH-1:0] first_addr_q, last_addr_q;

   always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
      if (!ctl_reset_n) begin
         first_seen_q <= 1'b0;
         first_dbe_q  <= 1'b0;
         first_addr_q <= '0;
         last_addr_q  <= '0;
      end else if (any_ev) begin
         last_addr_q <= rdata_addr;
         if (cfg_clr_intr || !first_seen_q) begin
            first_seen_q <= 1'b1;
            first_dbe_q  <= dbe_ev;
            first_addr_q <= rdata_addr;
         end
      end else if (cfg_clr_intr) begin
         first_seen_q <= 1'b0;
         first_dbe_q  <= 1'b0;
         first_addr_q <= '0;
         last_addr_q  <= '0;
      end
   end

   assign first_err_addr   = first_addr_q;
   assign last_err_addr    = last_addr_q;
   assign first_err_is_dbe = first_dbe_q;
`endif

endmodule

// File: tb/tb_alt_mem_ddrx_ecc_scrub_ctrl.sv
// Directed bench for the ECC scrub controller: counters, interrupt, queue
// overflow, scrub handshake ordering and asynchronous reset.
module tb_alt_mem_ddrx_ecc_scrub_ctrl;
   localparam int AW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_enable_ecc, cfg_enable_auto_corr, cfg_err_intr_en, cfg_clr_intr;
   logic          rdata_valid, err_corrected, err_fatal;
   logic [AW-1:0] rdata_addr;
   logic [CW-1:0] sbe_count, dbe_count;
   logic          err_intr, scrub_overflow, scrub_busy;
`ifdef ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN
   logic [AW-1:0] first_err_addr, last_err_addr;
   logic          first_err_is_dbe;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   alt_mem_ddrx_ecc_scrub_ctrl_if #(.ADDR_W(AW)) sif ();

   alt_mem_ddrx_ecc_scrub_ctrl #(
      .CFG_LOCAL_ADDR_WIDTH(AW), .CFG_ERR_CNT_WIDTH(CW), .CFG_SCRUB_FIFO_DEPTH(4)
   ) dut (
      .ctl_clk(clk), .ctl_reset_n(rst_n),
      .cfg_enable_ecc(cfg_enable_ecc), .cfg_enable_auto_corr(cfg_enable_auto_corr),
      .cfg_err_intr_en(cfg_err_intr_en), .cfg_clr_intr(cfg_clr_intr),
      .rdata_valid(rdata_valid), .rdata_addr(rdata_addr),
      .err_corrected(err_corrected), .err_fatal(err_fatal),
      .scrub_if(sif.master),
      .sbe_count(sbe_count), .dbe_count(dbe_count), .err_intr(err_intr),
      .scrub_overflow(scrub_overflow), .scrub_busy(scrub_busy)
`ifdef ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN
      , .first_err_addr(first_err_addr), .last_err_addr(last_err_addr),
      .first_err_is_dbe(first_err_is_dbe)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [AW-1:0] a, input logic c, input logic f);
      rdata_valid = 1'b1; rdata_addr = a; err_corrected = c; err_fatal = f;
      step();
      rdata_valid = 1'b0; err_corrected = 1'b0; err_fatal = 1'b0;
   endtask

   task automatic clr_pulse();
      cfg_clr_intr = 1'b1;
      step();
      cfg_clr_intr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg_enable_ecc = 1'b1; cfg_enable_auto_corr = 1'b1; cfg_err_intr_en = 1'b1;
      cfg_clr_intr = 1'b0; rdata_valid = 1'b0; rdata_addr = '0;
      err_corrected = 1'b0; err_fatal = 1'b0;
      sif.scrub_ack = 1'b0; sif.scrub_done = 1'b0;
      #12;
      vec_cnt++; if ({sbe_count, dbe_count} !== 16'h0) begin err_cnt++; $display("FAIL reset_counts: got %0h expected 0", {sbe_count, dbe_count}); end
      vec_cnt++; if ({err_intr, scrub_overflow, scrub_busy, sif.scrub_req} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags: got %b expected 0000", {err_intr, scrub_overflow, scrub_busy, sif.scrub_req}); end
      vec_cnt++; if (sif.scrub_addr !== '0) begin err_cnt++; $display("FAIL reset_addr: got %0h expected 0", sif.scrub_addr); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_scrub();
      beat(32'h100, 1'b1, 1'b0);
      vec_cnt++; if (sbe_count !== 8'd1) begin err_cnt++; $display("FAIL t1_sbe: got %0d expected 1", sbe_count); end
      vec_cnt++; if (err_intr !== 1'b1) begin err_cnt++; $display("FAIL t1_intr: got %b expected 1", err_intr); end
      vec_cnt++; if (sif.scrub_req !== 1'b0) begin err_cnt++; $display("FAIL t1_req_early: got %b expected 0", sif.scrub_req); end
      step();
      vec_cnt++; if (sif.scrub_req !== 1'b1 || sif.scrub_addr !== 32'h100) begin err_cnt++; $display("FAIL t1_req: got req=%b addr=%0h expected req=1 addr=100", sif.scrub_req, sif.scrub_addr); end
      sif.scrub_ack = 1'b1;
      step();
      sif.scrub_ack = 1'b0;
      vec_cnt++; if (sif.scrub_req !== 1'b0 || scrub_busy !== 1'b1) begin err_cnt++; $display("FAIL t1_wait: got req=%b busy=%b expected req=0 busy=1", sif.scrub_req, scrub_busy); end
      step(); step();
      sif.scrub_done = 1'b1;
      step();
      sif.scrub_done = 1'b0;
      vec_cnt++; if (scrub_busy !== 1'b0 || sif.scrub_req !== 1'b0) begin err_cnt++; $display("FAIL t1_done: got busy=%b req=%b expected 0 0", scrub_busy, sif.scrub_req); end
   endtask

   task automatic test_overflow();
      clr_pulse();
      for (int i = 1; i <= 5; i++) beat(32'(i * 16), 1'b1, 1'b0);
      vec_cnt++; if (sbe_count !== 8'd5) begin err_cnt++; $display("FAIL t2_sbe: got %0d expected 5", sbe_count); end
      vec_cnt++; if (scrub_overflow !== 1'b1) begin err_cnt++; $display("FAIL t2_ovf: got %b expected 1", scrub_overflow); end
      for (int k = 0; k < 4; k++) begin
         vec_cnt++; if (sif.scrub_req !== 1'b1 || sif.scrub_addr !== 32'((k + 1) * 16)) begin err_cnt++; $display("FAIL t2_scrub%0d: got req=%b addr=%0h expected req=1 addr=%0h", k, sif.scrub_req, sif.scrub_addr, (k + 1) * 16); end
         sif.scrub_ack = 1'b1; step(); sif.scrub_ack = 1'b0;
         sif.scrub_done = 1'b1; step(); sif.scrub_done = 1'b0;
         step();
      end
      vec_cnt++; if (scrub_busy !== 1'b0 || sif.scrub_req !== 1'b0) begin err_cnt++; $display("FAIL t2_drained: got busy=%b req=%b expected 0 0", scrub_busy, sif.scrub_req); end
   endtask

   task automatic test_clr_same_cycle();
      cfg_enable_auto_corr = 1'b0;
      beat(32'h600, 1'b1, 1'b0);
      beat(32'h610, 1'b1, 1'b0);
      vec_cnt++; if (sbe_count !== 8'd7 || scrub_busy !== 1'b0) begin err_cnt++; $display("FAIL t4_pre: got sbe=%0d busy=%b expected 7 0", sbe_count, scrub_busy); end
      cfg_clr_intr = 1'b1;
      beat(32'h700, 1'b1, 1'b0);
      cfg_clr_intr = 1'b0;
      vec_cnt++; if (sbe_count !== 8'd1 || dbe_count !== 8'd0) begin err_cnt++; $display("FAIL t4_cnt: got sbe=%0d dbe=%0d expected 1 0", sbe_count, dbe_count); end
      vec_cnt++; if (err_intr !== 1'b1 || scrub_overflow !== 1'b0) begin err_cnt++; $display("FAIL t4_flags: got intr=%b ovf=%b expected 1 0", err_intr, scrub_overflow); end
      cfg_enable_auto_corr = 1'b1;
   endtask

   task automatic test_dbe_saturate();
      logic seen_req;
      seen_req = 1'b0;
      clr_pulse();
      rdata_valid = 1'b1; err_fatal = 1'b1; rdata_addr = 32'h900;
      for (int i = 0; i < 254; i++) begin step(); if (sif.scrub_req) seen_req = 1'b1; end
      vec_cnt++; if (dbe_count !== 8'd254) begin err_cnt++; $display("FAIL t3_dbe254: got %0d expected 254", dbe_count); end
      for (int i = 0; i < 46; i++) begin step(); if (sif.scrub_req) seen_req = 1'b1; end
      rdata_valid = 1'b0; err_fatal = 1'b0;
      vec_cnt++; if (dbe_count !== 8'd255) begin err_cnt++; $display("FAIL t3_sat: got %0d expected 255", dbe_count); end
      vec_cnt++; if (seen_req !== 1'b0 || scrub_busy !== 1'b0 || sbe_count !== 8'd0) begin err_cnt++; $display("FAIL t3_noscrub: got req_seen=%b busy=%b sbe=%0d expected 0 0 0", seen_req, scrub_busy, sbe_count); end
   endtask

   task automatic test_valid_qualify();
      clr_pulse();
      rdata_valid = 1'b0; err_corrected = 1'b1; err_fatal = 1'b1;
      repeat (3) step();
      err_corrected = 1'b0; err_fatal = 1'b0;
      vec_cnt++; if ({sbe_count, dbe_count, err_intr, scrub_busy} !== 18'h0) begin err_cnt++; $display("FAIL t5_novalid: got sbe=%0d dbe=%0d intr=%b busy=%b expected all 0", sbe_count, dbe_count, err_intr, scrub_busy); end
      beat(32'h55, 1'b1, 1'b1);
      vec_cnt++; if (sbe_count !== 8'd0 || dbe_count !== 8'd1 || scrub_busy !== 1'b0) begin err_cnt++; $display("FAIL t5_valid: got sbe=%0d dbe=%0d busy=%b expected 0 1 0", sbe_count, dbe_count, scrub_busy); end
      cfg_enable_ecc = 1'b0;
      beat(32'h66, 1'b1, 1'b0);
      cfg_enable_ecc = 1'b1;
      vec_cnt++; if (sbe_count !== 8'd0 || scrub_busy !== 1'b0) begin err_cnt++; $display("FAIL t5_eccoff: got sbe=%0d busy=%b expected 0 0", sbe_count, scrub_busy); end
   endtask

   task automatic test_async_reset();
      logic seen_req;
      seen_req = 1'b0;
      beat(32'h200, 1'b1, 1'b0);
      step();
      sif.scrub_ack = 1'b1; step(); sif.scrub_ack = 1'b0;
      vec_cnt++; if (sif.scrub_req !== 1'b0 || scrub_busy !== 1'b1 || sbe_count !== 8'd1) begin err_cnt++; $display("FAIL t6_inwait: got req=%b busy=%b sbe=%0d expected 0 1 1", sif.scrub_req, scrub_busy, sbe_count); end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++; if ({sbe_count, dbe_count, err_intr, scrub_overflow, scrub_busy, sif.scrub_req} !== 20'h0 || sif.scrub_addr !== '0) begin err_cnt++; $display("FAIL t6_async: got sbe=%0d dbe=%0d intr=%b busy=%b addr=%0h expected all 0", sbe_count, dbe_count, err_intr, scrub_busy, sif.scrub_addr); end
      @(negedge clk); rst_n = 1'b1;
      sif.scrub_done = 1'b1; step(); sif.scrub_done = 1'b0;
      repeat (4) begin step(); if (sif.scrub_req) seen_req = 1'b1; end
      vec_cnt++; if (seen_req !== 1'b0 || scrub_busy !== 1'b0) begin err_cnt++; $display("FAIL t6_quiet: got req_seen=%b busy=%b expected 0 0", seen_req, scrub_busy); end
      beat(32'h300, 1'b1, 1'b0);
      step();
      vec_cnt++; if (sif.scrub_req !== 1'b1 || sif.scrub_addr !== 32'h300) begin err_cnt++; $display("FAIL t6_new: got req=%b addr=%0h expected 1 300", sif.scrub_req, sif.scrub_addr); end
      sif.scrub_ack = 1'b1; step(); sif.scrub_ack = 1'b0;
      sif.scrub_done = 1'b1; step(); sif.scrub_done = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_scrub();
      test_overflow();
      test_clr_same_cycle();
      test_dbe_saturate();
      test_valid_qualify();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alt_mem_ddrx_ecc_scrub_ctrl.md
Name: alt_mem_ddrx_ecc_scrub_ctrl

Overview:
Sits after the ECC read-path decoder in the controller. Qualifies decoder error flags against read-data valid and keeps saturating single-bit error (SBE) and double-bit error (DBE) counters plus a sticky interrupt. Queues the addresses of SBE-corrected reads and sequences one auto-correction (scrub read-modify-write) command per queued address toward the command arbiter, using a request/acknowledge/done handshake.

Parameters:
CFG_LOCAL_ADDR_WIDTH, 32, width of the local address tagged on each read beat
CFG_ERR_CNT_WIDTH, 8, width of each saturating error counter
CFG_SCRUB_FIFO_DEPTH, 4, scrub address queue depth; power of two, at least 2

Ports:
ctl_clk  in  1  controller clock; all logic on rising edge
ctl_reset_n  in  1  asynchronous active-low reset
cfg_enable_ecc  in  1  ECC enabled; when 0, all error inputs are ignored
cfg_enable_auto_corr  in  1  allow new scrub commands to launch
cfg_err_intr_en  in  1  allow errors to set err_intr
cfg_clr_intr  in  1  one-cycle pulse: clear counters, err_intr and scrub_overflow
rdata_valid  in  1  decoder output beat valid
rdata_addr  in  CFG_LOCAL_ADDR_WIDTH  address tag of the current beat
err_corrected  in  1  decoder flag: corrected error on this beat
err_fatal  in  1  decoder flag: uncorrectable error on this beat
scrub_req  out  1  scrub command request
scrub_addr  out  CFG_LOCAL_ADDR_WIDTH  address to scrub; stable while scrub_req=1
scrub_ack  in  1  arbiter accepted the command
scrub_done  in  1  scrub write-back completed
sbe_count  out  CFG_ERR_CNT_WIDTH  saturating SBE count
dbe_count  out  CFG_ERR_CNT_WIDTH  saturating DBE count
err_intr  out  1  sticky error interrupt
scrub_overflow  out  1  sticky flag: SBE address dropped because queue was full
scrub_busy  out  1  FSM is not IDLE, or queue is not empty

Behaviour:
- Reset: every output is 0, the queue is empty, and the FSM is IDLE. Reset is asynchronous and valid mid-operation: any in-flight request is abandoned with no handshake completion.
- Qualification:
  - sbe_ev = cfg_enable_ecc & rdata_valid & err_corrected & ~err_fatal
  - dbe_ev = cfg_enable_ecc & rdata_valid & err_fatal
  - Both events are single-cycle. Error flags without rdata_valid are ignored.
- Counters: increment on their event, registered, 1-cycle latency. They saturate at all-ones and never wrap.
- cfg_clr_intr:
  - Clears both counters, err_intr and scrub_overflow.
  - If an event arrives in the same cycle as the clear, the event wins: that counter becomes 1, and err_intr is set if enabled.
  - The scrub queue and FSM are unaffected.
- err_intr: set on the cycle after any sbe_ev or dbe_ev while cfg_err_intr_en=1. Only cfg_clr_intr or reset clears it.
- Queue push: on sbe_ev with cfg_enable_auto_corr=1, rdata_addr is pushed.
  - Queue full and no pop in the same cycle: the address is dropped, scrub_overflow is set, and the SBE is still counted.
  - Simultaneous push and pop are both honoured, including when the queue is full.
  - DBE addresses are never queued.
- FSM:
  - IDLE: if the queue is not empty and cfg_enable_auto_corr=1, go to REQ on the next cycle. scrub_addr is driven from the queue head.
  - REQ: scrub_req=1 and scrub_addr is held. When scrub_ack=1, go to WAIT and deassert scrub_req on the next cycle. A launched request is never withdrawn, even if cfg_enable_auto_corr drops.
  - WAIT: scrub_req=0. When scrub_done=1, pop the queue head and return to IDLE.
  - scrub_done is ignored outside WAIT. scrub_ack is ignored outside REQ.
  - At most one scrub is in flight.
  - Minimum spacing: 3 cycles from one scrub_req rising edge to the next, given same-cycle ack and done.
- cfg_enable_auto_corr=0: no new pushes and no new launches. Queued entries are retained and drained once the enable returns.
- cfg_enable_ecc=0: events are suppressed. Scrubs already queued or in flight still complete.

Optional Feature:
Macro: ALT_MEM_DDRX_ECC_ERR_ADDR_LOG_EN.
- Defined:
  - Adds outputs first_err_addr and last_err_addr, each CFG_LOCAL_ADDR_WIDTH wide, plus first_err_is_dbe (1 bit).
  - first_err_addr captures rdata_addr on the first sbe_ev or dbe_ev after reset or cfg_clr_intr.
  - last_err_addr captures rdata_addr on every event.
  - All three reset and clear to 0. An event in the same cycle as a clear is captured as the first error.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
1. SBE at addr 0x100, ack at +2 cycles, done at +5 cycles -> sbe_count=1, err_intr=1. scrub_req rises 2 cycles after the event with scrub_addr=0x100, drops the cycle after ack. scrub_busy=0 after done.
2. Five SBEs on back-to-back beats (addrs 0x10..0x50) while the arbiter stalls ack -> 4 addresses queued, 0x50 dropped, scrub_overflow=1, sbe_count=5. Then scrubs 0x10, 0x20, 0x30, 0x40 are issued in order.
3. 300 DBE beats with CFG_ERR_CNT_WIDTH=8 -> dbe_count saturates at 255, no scrub_req ever.
4. cfg_clr_intr in the same cycle as an SBE, with counters previously at 7 -> sbe_count=1, err_intr=1, scrub_overflow=0.
5. err_fatal=1 and err_corrected=1 with rdata_valid=0 -> counters, queue and err_intr all unchanged. The same flags with rdata_valid=1 -> only dbe_count increments.
6. Reset asserted during WAIT -> all outputs 0 asynchronously. After reset release, no scrub_req until a new SBE arrives.
